// File: rtl/ipv4_decoder_if.sv
// ----------------------------------------------------------------------------
// ipv4_decoder_if
//   Groups the word stream into the IPv4 decoder together with the payload
//   stream and pseudo-header fields it hands to the TCP/UDP decoders.
//
//   Upstream side : data[31:0], start
//   Downstream    : data_out[31:0], start_out, wr_en, fin,
//                   src_ip[31:0], dest_ip[31:0], len_tcp[15:0], protocol[7:0],
//                   tcp_sel, udp_sel
//   Status        : ok, err[3:0] {bad_checksum, bad_length, fragment,
//                   bad_version_or_ihl}
//
//   master : the datagram source (drives data/start, observes the rest)
//   slave  : the decoder
// ----------------------------------------------------------------------------
interface ipv4_decoder_if;
    logic [31:0] data;
    logic        start;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] len_tcp;
    logic [7:0]  protocol;
    logic [31:0] data_out;
    logic        start_out;
    logic        wr_en;
    logic        tcp_sel;
    logic        udp_sel;
    logic        ok;
    logic [3:0]  err;
    logic        fin;

    modport master (
        output data, start,
        input  src_ip, dest_ip, len_tcp, protocol, data_out, start_out,
               wr_en, tcp_sel, udp_sel, ok, err, fin
    );

    modport slave (
        input  data, start,
        output src_ip, dest_ip, len_tcp, protocol, data_out, start_out,
               wr_en, tcp_sel, udp_sel, ok, err, fin
    );
endinterface

// File: rtl/ipv4_decoder.sv
// ----------------------------------------------------------------------------
// ipv4_decoder
//   Parses and validates an IPv4 header arriving as 32-bit big-endian words
//   (one per cycle, first word flagged by start), checks the header checksum,
//   then forwards the transport payload with a one-cycle latency together
//   with the pseudo-header fields the TCP/UDP decoders need. Datagrams that
//   fail validation, or carry a protocol other than TCP/UDP, are consumed
//   silently apart from a single fin pulse.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-low reset
//     bus    : ipv4_decoder_if.slave (see interface header for signals)
//
//   Parameter
//     MAX_IHL : largest accepted IHL in 32-bit words (5..15)
// ----------------------------------------------------------------------------
module ipv4_decoder #(
    parameter int MAX_IHL = 15
) (
    input  logic           clk,
    input  logic           reset,
    ipv4_decoder_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, HDR, OPT, PAY, DROP} state_t;

    localparam logic [4:0] MAX_IHL_W = 5'(MAX_IHL);

    state_t      state_q, state_d;
    logic [3:0]  hdr_idx_q, hdr_idx_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [13:0] rem_q, rem_d;
    logic [15:0] csum_q, csum_d;
    logic        first_q, first_d;

    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dest_ip_q, dest_ip_d;
    logic [15:0] len_tcp_q, len_tcp_d;
    logic [7:0]  protocol_q, protocol_d;
    logic [31:0] data_out_q, data_out_d;
    logic        start_out_q, start_out_d;
    logic        wr_en_q, wr_en_d;
    logic        tcp_sel_q, tcp_sel_d;
    logic        udp_sel_q, udp_sel_d;
    logic        ok_q, ok_d;
    logic [3:0]  err_q, err_d;
    logic        fin_q, fin_d;

    // Word-0 field decode, only meaningful when the current word is word 0.
    logic [3:0]  w_ver;
    logic [3:0]  w_ihl;
    logic [15:0] w_total;
    logic [15:0] w_four_ihl;
    logic        bad_ver;
    logic        bad_len;
    logic [14:0] tot_words;
    logic [13:0] pay_words;

    assign w_ver      = bus.data[31:28];
    assign w_ihl      = bus.data[27:24];
    assign w_total    = bus.data[15:0];
    assign w_four_ihl = {10'd0, w_ihl, 2'b00};
    assign bad_ver    = (w_ver != 4'd4) || (w_ihl < 4'd5) || ({1'b0, w_ihl} > MAX_IHL_W);
    assign bad_len    = w_total < w_four_ihl;
    // ceil(total_length / 4) and ceil(len_tcp / 4) without a wide adder.
    assign tot_words  = {1'b0, w_total[15:2]} + 15'(|w_total[1:0]);
    assign pay_words  = len_tcp_q[15:2] + 14'(|len_tcp_q[1:0]);

    // One's-complement 16-bit add: 17-bit sum with the carry wrapped back in.
    function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    logic [3:0]  idx;
    logic [15:0] csum_new;
    logic        known_proto;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        ihl_d       = ihl_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        first_d     = first_q;
        src_ip_d    = src_ip_q;
        dest_ip_d   = dest_ip_q;
        len_tcp_d   = len_tcp_q;
        protocol_d  = protocol_q;
        data_out_d  = data_out_q;
        tcp_sel_d   = tcp_sel_q;
        udp_sel_d   = udp_sel_q;
        err_d       = err_q;
        start_out_d = 1'b0;
        wr_en_d     = 1'b0;
        ok_d        = 1'b0;
        fin_d       = 1'b0;
        idx         = hdr_idx_q;
        csum_new    = csum_q;
        known_proto = 1'b0;

        // start wins in every state: it aborts whatever was in flight (no fin)
        // and this word is parsed as header word 0.
        if (bus.start || state_q == HDR || state_q == OPT) begin
            idx       = bus.start ? 4'd0 : hdr_idx_q;
            csum_new  = add1c(add1c(bus.start ? 16'd0 : csum_q, bus.data[31:16]),
                              bus.data[15:0]);
            csum_d    = csum_new;
            hdr_idx_d = idx + 4'd1;
            state_d   = (idx >= 4'd4) ? OPT : HDR;

            if (bus.start) begin
                err_d     = 4'd0;
                tcp_sel_d = 1'b0;
                udp_sel_d = 1'b0;
                first_d   = 1'b0;
            end

            case (idx)
                4'd0: begin
                    ihl_d     = w_ihl;
                    err_d[0]  = bad_ver;
                    err_d[2]  = bad_len;
                    len_tcp_d = bad_len ? 16'd0 : w_total - w_four_ihl;
                    // Malformed word 0: drop at once, no point waiting for the
                    // checksum. Word 0 itself is already consumed.
                    if (bad_ver || bad_len) begin
                        fin_d   = 1'b1;
                        rem_d   = 14'(tot_words - 15'd1);
                        state_d = (tot_words > 15'd1) ? DROP : IDLE;
                    end
                end
                4'd1: err_d[1] = bus.data[13] || (bus.data[12:0] != 13'd0);
                4'd2: protocol_d = bus.data[23:16];
                4'd3: src_ip_d = bus.data;
                4'd4: dest_ip_d = bus.data;
                default: ;
            endcase

            // Last header word (IHL >= 5 here, so idx 0 is never the last).
            if (idx != 4'd0 && idx == ihl_q - 4'd1) begin
                err_d[3]    = (csum_new != 16'hFFFF);
                known_proto = (protocol_q == 8'd6) || (protocol_q == 8'd17);
                rem_d       = pay_words;
                if (err_d[3] || err_d[1] || !known_proto) begin
                    fin_d   = 1'b1;
                    state_d = (pay_words != 14'd0) ? DROP : IDLE;
                end else begin
                    ok_d      = 1'b1;
                    tcp_sel_d = (protocol_q == 8'd6);
                    udp_sel_d = (protocol_q == 8'd17);
                    first_d   = 1'b1;
                    if (pay_words == 14'd0) begin
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PAY;
                    end
                end
            end
        end else if (state_q == PAY) begin
            data_out_d  = bus.data;
            wr_en_d     = 1'b1;
            start_out_d = first_q;
            first_d     = 1'b0;
            rem_d       = rem_q - 14'd1;
            if (rem_q == 14'd1) begin
                fin_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == DROP) begin
            rem_d = rem_q - 14'd1;
            if (rem_q == 14'd1) begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge only (no async sensitivity),
    // and all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            hdr_idx_q   <= 4'd0;
            ihl_q       <= 4'd0;
            rem_q       <= 14'd0;
            csum_q      <= 16'd0;
            first_q     <= 1'b0;
            src_ip_q    <= 32'd0;
            dest_ip_q   <= 32'd0;
            len_tcp_q   <= 16'd0;
            protocol_q  <= 8'd0;
            data_out_q  <= 32'd0;
            start_out_q <= 1'b0;
            wr_en_q     <= 1'b0;
            tcp_sel_q   <= 1'b0;
            udp_sel_q   <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 4'd0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            ihl_q       <= ihl_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            first_q     <= first_d;
            src_ip_q    <= src_ip_d;
            dest_ip_q   <= dest_ip_d;
            len_tcp_q   <= len_tcp_d;
            protocol_q  <= protocol_d;
            data_out_q  <= data_out_d;
            start_out_q <= start_out_d;
            wr_en_q     <= wr_en_d;
            tcp_sel_q   <= tcp_sel_d;
            udp_sel_q   <= udp_sel_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            fin_q       <= fin_d;
        end
    end

    assign bus.src_ip    = src_ip_q;
    assign bus.dest_ip   = dest_ip_q;
    assign bus.len_tcp   = len_tcp_q;
    assign bus.protocol  = protocol_q;
    assign bus.data_out  = data_out_q;
    assign bus.start_out = start_out_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.tcp_sel   = tcp_sel_q;
    assign bus.udp_sel   = udp_sel_q;
    assign bus.ok        = ok_q;
    assign bus.err       = err_q;
    assign bus.fin       = fin_q;

endmodule

// File: tb/tb_ipv4_decoder.sv
// ----------------------------------------------------------------------------
// tb_ipv4_decoder
//   Directed datagrams drive the decoder; a datagram-level model turns each
//   one into a per-cycle list of expected outputs, and a single compare
//   process checks the DUT against that list one cycle after every word.
//   A few literal expectations after each case pin the model.
// ----------------------------------------------------------------------------
module tb_ipv4_decoder;

    localparam int MAX_IHL = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;

    ipv4_decoder_if bus ();

    ipv4_decoder #(.MAX_IHL(MAX_IHL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        all_zero;
        logic        ok;
        logic        fin;
        logic        wr_en;
        logic        start_out;
        logic [31:0] data_out;
        logic [3:0]  err;
        logic        chk_hdr;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic [7:0]  proto;
        logic        tcp;
        logic        udp;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan[$];
    exp_t ce;
    logic [3:0] last_err = 4'd0;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int fin_cnt = 0;
    int ok_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Internet checksum sum over the first n header words, folded at the end.
    function automatic logic [15:0] ones_sum(input logic [31:0] w[$], input int n);
        int unsigned s;
        s = 0;
        for (int i = 0; i < n && i < w.size(); i++) begin
            s += w[i][31:16];
            s += w[i][15:0];
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    // Expected outputs for the first n words of datagram w, one entry per word.
    task automatic build(input logic [31:0] w[$], input int n);
        int h, tot, pay;
        logic [7:0] proto;
        logic bad0, bad2, frag, cbad, pass;
        logic [3:0] err;
        exp_t e;
        h     = int'(w[0][27:24]);
        tot   = int'(w[0][15:0]);
        proto = w[2][23:16];
        bad0  = (w[0][31:28] != 4'd4) || (h < 5) || (h > MAX_IHL);
        bad2  = tot < 4 * h;
        frag  = w[1][13] || (w[1][12:0] != 13'd0);
        cbad  = ones_sum(w, h) != 16'hFFFF;
        pass  = !frag && !cbad && (proto == 8'd6 || proto == 8'd17);
        pay   = (tot - 4 * h + 3) / 4;
        err   = 4'd0;
        plan.delete();
        for (int t = 0; t < n; t++) begin
            e = '0;
            if (bad0 || bad2) begin
                err   = {1'b0, bad2, 1'b0, bad0};
                e.fin = (t == 0);
            end else begin
                err = {cbad && (t >= h - 1), 1'b0, frag && (t >= 1), 1'b0};
                if (t == h - 1) begin
                    e.ok  = pass;
                    e.fin = !pass || (pay == 0);
                end
                if (pass && t >= h && t < h + pay) begin
                    e.wr_en     = 1'b1;
                    e.data_out  = w[t];
                    e.start_out = (t == h);
                    e.fin       = (t == h + pay - 1);
                end
                if (e.ok || e.wr_en) begin
                    e.chk_hdr = 1'b1;
                    e.src     = w[3];
                    e.dst     = w[4];
                    e.len     = 16'(tot - 4 * h);
                    e.proto   = proto;
                    e.tcp     = (proto == 8'd6);
                    e.udp     = (proto == 8'd17);
                end
            end
            e.err = err;
            plan.push_back(e);
        end
        last_err = err;
    endtask

    task automatic send(input logic [31:0] w[$], input int n);
        build(w, n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.start = (k == 0);
            bus.data  = w[k];
            exp_q.push_back(plan[k]);
        end
    endtask

    task automatic idle(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.data  = 32'd0;
            e = '0;
            e.err = last_err;
            exp_q.push_back(e);
        end
    endtask

    task automatic hold_reset(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset     = 1'b0;
            bus.start = 1'b0;
            bus.data  = 32'd0;
            e = '0;
            e.all_zero = 1'b1;
            exp_q.push_back(e);
        end
        last_err = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        e = '0;
        exp_q.push_back(e);
    endtask

    // Compare process: one expectation per cycle, sampled 1 time unit after
    // the edge that produced it.
    always begin
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) wr_cnt++;
        if (bus.fin === 1'b1)   fin_cnt++;
        if (bus.ok === 1'b1)    ok_cnt++;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            if (ce.all_zero) begin
                check("reset flags", {26'd0, bus.ok, bus.fin, bus.wr_en, bus.start_out,
                                      bus.tcp_sel, bus.udp_sel}, 32'd0);
                check("reset err", {28'd0, bus.err}, 32'd0);
                check("reset src_ip", bus.src_ip, 32'd0);
                check("reset dest_ip", bus.dest_ip, 32'd0);
                check("reset data_out", bus.data_out, 32'd0);
                check("reset len/proto", {8'd0, bus.len_tcp, bus.protocol}, 32'd0);
            end else begin
                check("ok", {31'd0, bus.ok}, {31'd0, ce.ok});
                check("fin", {31'd0, bus.fin}, {31'd0, ce.fin});
                check("wr_en", {31'd0, bus.wr_en}, {31'd0, ce.wr_en});
                check("start_out", {31'd0, bus.start_out}, {31'd0, ce.start_out});
                check("err", {28'd0, bus.err}, {28'd0, ce.err});
                if (ce.wr_en) check("data_out", bus.data_out, ce.data_out);
                if (ce.chk_hdr) begin
                    check("src_ip", bus.src_ip, ce.src);
                    check("dest_ip", bus.dest_ip, ce.dst);
                    check("len_tcp", {16'd0, bus.len_tcp}, {16'd0, ce.len});
                    check("protocol", {24'd0, bus.protocol}, {24'd0, ce.proto});
                    check("sel", {30'd0, bus.tcp_sel, bus.udp_sel}, {30'd0, ce.tcp, ce.udp});
                end
            end
        end
    end

    logic [31:0] c1[$];
    logic [31:0] c2[$];
    logic [31:0] c3[$];
    logic [31:0] v[$];
    int b_wr, b_fin, b_ok;

    task automatic mark();
        b_wr  = wr_cnt;
        b_fin = fin_cnt;
        b_ok  = ok_cnt;
    endtask

    task automatic counts(input string name, input int wr, input int fin, input int ok);
        check({name, " wr_en pulses"}, 32'(wr_cnt - b_wr), 32'(wr));
        check({name, " fin pulses"}, 32'(fin_cnt - b_fin), 32'(fin));
        check({name, " ok pulses"}, 32'(ok_cnt - b_ok), 32'(ok));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data  = 32'd0;

        // Case 1 vector: UDP, 95-byte payload in 24 words.
        c1 = '{32'h45000073, 32'h00004000, 32'h4011B861, 32'hC0A80001, 32'hC0A800C7};
        for (int i = 0; i < 24; i++) c1.push_back(32'hD0000000 + 32'(i));
        // Case 2: checksum off by one.
        c2 = c1;
        c2[2] = 32'h4011B862;
        // Case 3: IHL=6 with one option word, TCP, 11-byte payload.
        c3 = '{32'h46000023, 32'h00004000, 32'h4006B5BA, 32'hC0A80001, 32'hC0A800C7,
               32'h01010101, 32'hAABBCCDD, 32'h11223344, 32'h55667700};

        hold_reset(3);
        idle(2);

        // Case 1
        mark();
        send(c1, c1.size());
        idle(2);
        counts("case1", 24, 1, 1);
        check("case1 len_tcp", {16'd0, bus.len_tcp}, 32'h0000005F);
        check("case1 src_ip", bus.src_ip, 32'hC0A80001);
        check("case1 udp_sel", {31'd0, bus.udp_sel}, 32'd1);
        check("case1 err", {28'd0, bus.err}, 32'd0);

        // Case 2 then case 3 back to back
        mark();
        send(c2, c2.size());
        @(posedge clk); #2;
        check("case2 err", {28'd0, bus.err}, 32'h8);
        counts("case2", 0, 1, 0);
        mark();
        send(c3, c3.size());
        idle(2);
        counts("case3", 3, 1, 1);
        check("case3 tcp_sel", {31'd0, bus.tcp_sel}, 32'd1);
        check("case3 len_tcp", {16'd0, bus.len_tcp}, 32'd11);

        // Case 4a: MF set (checksum fixed up so only the fragment check fails)
        v = c1;
        v[1] = 32'h00002000;
        v[2] = 32'h40110000;
        v[2][15:0] = ~ones_sum(v, 5);
        mark();
        send(v, v.size());
        idle(1);
        counts("case4 mf", 0, 1, 0);
        check("case4 mf err", {28'd0, bus.err}, 32'h2);

        // Case 4b: version 6 -> immediate drop of the 5-word datagram
        v = '{32'h65000014, 32'h00000000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
        mark();
        send(v, v.size());
        idle(1);
        counts("case4 ver", 0, 1, 0);
        check("case4 ver err", {28'd0, bus.err}, 32'h1);

        // total_length 16 < 4*IHL -> bad length, 4 words consumed
        v = '{32'h45000010, 32'h00000000, 32'h40110000, 32'hC0A80001};
        mark();
        send(v, v.size());
        idle(1);
        counts("short total", 0, 1, 0);
        check("short total err", {28'd0, bus.err}, 32'h4);

        // Zero-length payload: ok and fin together
        v = '{32'h45000014, 32'h00000000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
        v[2][15:0] = ~ones_sum(v, 5);
        mark();
        send(v, v.size());
        idle(1);
        counts("empty payload", 0, 1, 1);

        // Unsupported protocol (ICMP): silent drop of two payload words
        v = '{32'h4500001C, 32'h00000000, 32'h40010000, 32'hC0A80001, 32'hC0A800C7,
              32'h12345678, 32'h9ABCDEF0};
        v[2][15:0] = ~ones_sum(v, 5);
        mark();
        send(v, v.size());
        idle(1);
        counts("icmp drop", 0, 1, 0);
        check("icmp err", {28'd0, bus.err}, 32'd0);

        // Case 5: reset during payload word 2, then a clean datagram
        send(c1, 7);
        hold_reset(1);
        idle(2);
        mark();
        send(c1, c1.size());
        idle(2);
        counts("case5 after reset", 24, 1, 1);

        // Case 6: restart at header word 3; aborted datagram gives no fin
        mark();
        send(c1, 3);
        send(c1, c1.size());
        idle(3);
        counts("case6 abort", 24, 1, 1);
        check("case6 len_tcp", {16'd0, bus.len_tcp}, 32'h0000005F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
